sp_ram_ctrl: RTL and testbench
==============================

// Module: sp_ram_ctrl
// PURPOSE
//  Initiator/controller for single_port_sync_ram: converts a valid/ready request stream into
//  the RAM's cs/we/oe/addr pin protocol and owns its half of the shared inout data bus.
//  Writes complete in 1 RAM cycle. Reads use 2 RAM cycles: address phase, then output-enable
//  phase. Read data is returned on a valid/ready response channel that supports back-pressure.
//  Sits between a processing engine and one RAM instance; one request in flight at a time.
// PARAMETERS
//  ADDR_WIDTH  5   RAM address width; must match the attached RAM
//  DATA_WIDTH  24  RAM data width; must match the attached RAM
// PORTS
//  clk        in   1           system clock; all logic on posedge
//  rst        in   1           synchronous, active-high reset
//  req_valid  in   1           request present
//  req_ready  out  1           controller can accept a request (IDLE only)
//  req_we     in   1           1 = write, 0 = read
//  req_addr   in   ADDR_WIDTH  request address
//  req_wdata  in   DATA_WIDTH  write data; ignored for reads
//  wr_ack     out  1           1-cycle pulse: a RAM write is being committed this cycle
//  rsp_valid  out  1           read data available
//  rsp_ready  in   1           consumer accepts read data
//  rsp_rdata  out  DATA_WIDTH  read data; held stable while rsp_valid=1
//  ram_addr   out  ADDR_WIDTH  to RAM addr
//  ram_data   inout DATA_WIDTH to/from RAM data
//  ram_cs     out  1           to RAM cs
//  ram_we     out  1           to RAM we
//  ram_oe     out  1           to RAM oe
// BEHAVIOUR
//  Reset: state=IDLE. req_ready=1 from the first cycle after reset. wr_ack, rsp_valid, ram_cs,
//   ram_we, ram_oe = 0. ram_addr and rsp_rdata = 0. ram_data = Z.
//  Request latch: req_addr, req_we and req_wdata are registered on the accept edge
//   (req_valid & req_ready).
//  FSM (registered state):
//   IDLE    : req_ready=1. Accept -> WRITE if req_we=1, else RD_ADDR.
//   WRITE   : cs=1, we=1, oe=0; drive ram_data=wdata; wr_ack=1; -> IDLE.
//   RD_ADDR : cs=1, we=0, oe=0; ram_data=Z. The RAM loads its output register at the
//             closing edge. -> RD_DATA.
//   RD_DATA : cs=1, we=0, oe=1; ram_data=Z (RAM drives it). Capture rsp_rdata<=ram_data at
//             the closing edge. -> RESP.
//   RESP    : rsp_valid=1; all RAM pins idle. On rsp_ready -> IDLE; otherwise hold state.
//  Pin decode: ram_cs/ram_we/ram_oe/wr_ack are decoded from the state register and gated
//   with ~rst, so no RAM access happens on a reset edge. ram_addr = latched address in all
//   non-IDLE states; it holds its last value in IDLE.
//  Bus ownership: ram_data is driven only in WRITE and is Z in every other state. The RAM
//   drives the bus only in RD_DATA, so there is never contention. ram_oe=1 only in RD_DATA.
//  Latency, write: accept edge E0, then WRITE cycle, then RAM commit at E1. req_ready is
//   high again after E1, so max throughput is 1 write per 2 cycles.
//  Latency, read: accept at E0; rsp_valid rises after E2 (3rd cycle after acceptance).
//   Minimum of 4 cycles per read, including the RESP cycle.
//  Response back-pressure: rsp_valid stays high and rsp_rdata stays stable until
//   rsp_valid & rsp_ready. req_ready=0 throughout.
//  Simultaneous events: req_valid is ignored outside IDLE. rst has priority over every
//   transition. rsp_ready while rsp_valid=0 is ignored.
//  Reset mid-operation: any state -> IDLE on the next edge. The aborted operation produces
//   no wr_ack and no rsp_valid. A RAM write in the reset cycle is suppressed by the ~rst gate.
// TESTING
//  1 After rst, read addr 0 with rsp_ready=1 -> rsp_rdata=24'hABCDEF, rsp_valid 3 cycles after
//    accept; ram_oe high exactly 1 cycle.
//  2 Write addr 5 <= 24'h123456, then read addr 5 -> wr_ack 1 cycle; read returns 24'h123456;
//    addr 4 still reads 24'h000000.
//  3 req_valid held for 3 writes (addr 1,2,3 = 24'h000011/22/33) -> accepted every 2 cycles;
//    read-back returns all 3 values.
//  4 Read addr 0 with rsp_ready=0 for 4 cycles -> rsp_valid/rsp_rdata stable and req_ready=0
//    throughout; IDLE the cycle after rsp_ready=1.
//  5 Assert rst during RD_DATA, then during WRITE to addr 7 (data 24'hFFFFFF) -> IDLE next
//    cycle, no rsp_valid/wr_ack; addr 7 reads 24'h000000.
//  6 Bus check across all scenarios -> ram_data never X; it is driven only in WRITE or when
//    ram_cs&ram_oe&!ram_we.

Source files
------------

// File: rtl/sp_ram_ctrl.sv
// Controller for a single-port synchronous RAM: turns a valid/ready request stream into
// cs/we/oe/addr pin activity and returns read data on a back-pressured response channel.
module sp_ram_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  wr_ack,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    accept;

    assign accept = req_valid & req_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? S_WRITE : S_RD_ADDR;
                end
            end
            S_WRITE:   state_d = S_IDLE;
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: begin
                // RAM drives the bus during this state; sample it at the closing edge
                rdata_d = ram_data;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
        wdata_q <= wdata_d;
    end

    // Pin strobes are gated with ~rst so a reset edge can never commit a RAM access
    assign req_ready = (state_q == S_IDLE) & ~rst;
    assign rsp_valid = (state_q == S_RESP) & ~rst;
    assign wr_ack    = (state_q == S_WRITE) & ~rst;
    assign ram_cs    = ((state_q == S_WRITE) | (state_q == S_RD_ADDR) | (state_q == S_RD_DATA)) & ~rst;
    assign ram_we    = (state_q == S_WRITE) & ~rst;
    assign ram_oe    = (state_q == S_RD_DATA) & ~rst;
    assign ram_addr  = addr_q;
    assign rsp_rdata = rdata_q;
    assign ram_data  = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Scoreboard bench for sp_ram_ctrl with a behavioural single-port synchronous RAM attached.
module tb_sp_ram_ctrl;

    localparam int AW = 5;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          wr_ack;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_cs, ram_we, ram_oe;

    sp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .wr_ack(wr_ack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write on cs&we, output register loads on the address phase
    logic [DW-1:0] mem [32];
    logic [DW-1:0] rd_q = '0;
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0] = 24'hABCDEF;
    end
    always @(posedge clk) begin
        if (ram_cs && ram_we)       mem[ram_addr] <= ram_data;
        else if (ram_cs && !ram_oe) rd_q <= mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? rd_q : {DW{1'bz}};

    logic [DW-1:0] exp_mem [32];
    logic [DW-1:0] sb_q [$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, ack_cnt = 0, oe_cnt = 0, rv_cnt = 0, hs_cnt = 0, first_rv = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Inputs are final here; evaluate what the coming edge will see, then advance to the next negedge
    task automatic tick();
        logic [DW-1:0] e;
        chk("bus_own", {30'd0, ram_oe & (ram_we | ~ram_cs), ram_we & ~ram_cs}, 32'd0);
        if (ram_oe) oe_cnt++;
        if (wr_ack) ack_cnt++;
        if (rsp_valid) begin
            rv_cnt++;
            if (first_rv < 0) first_rv = cyc;
        end
        if (rsp_valid && rsp_ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                e = sb_q.pop_front();
                chk("rdata", {8'd0, rsp_rdata}, {8'd0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Presents a request until accepted; leaves req_valid asserted for the caller to clear
    task automatic req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit commit, output int acc_cyc);
        logic acc;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        acc = 1'b0;
        acc_cyc = -1;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = req_ready;
            if (acc) acc_cyc = cyc;
            tick();
        end
        if (!acc) chk("req_timeout", 32'd0, 32'd1);
        else if (commit) begin
            if (we) exp_mem[a] = d;
            else    sb_q.push_back(exp_mem[a]);
        end
    endtask

    task automatic wait_rsp();
        int start;
        start = hs_cnt;
        for (int n = 0; n < 20 && hs_cnt == start; n++) tick();
        if (hs_cnt == start) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        int c;
        req(1'b0, a, '0, 1'b1, c);
        req_valid = 1'b0;
        wait_rsp();
    endtask

    initial begin
        int c0, c1, c2, ack0, rv0;
        logic [DW-1:0] held;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        exp_mem[0] = 24'hABCDEF;

        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_pins", {28'd0, wr_ack, ram_cs, ram_we, ram_oe}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_ram_addr", {27'd0, ram_addr}, 32'd0);
        chk("rst_rsp_rdata", {8'd0, rsp_rdata}, 32'd0);

        // 1: read of the preloaded word, latency and single oe cycle
        oe_cnt = 0; first_rv = -1;
        req(1'b0, 5'd0, '0, 1'b1, c0);
        req_valid = 1'b0;
        wait_rsp();
        chk("rd_latency", first_rv - c0, 32'd3);
        chk("oe_cycles", oe_cnt, 32'd1);

        // 2: write then read back, neighbour untouched
        ack0 = ack_cnt;
        req(1'b1, 5'd5, 24'h123456, 1'b1, c0);
        req_valid = 1'b0;
        tick();
        chk("wr_ack_pulses", ack_cnt - ack0, 32'd1);
        rd(5'd5);
        rd(5'd4);

        // 3: back-to-back writes with req_valid held
        req(1'b1, 5'd1, 24'h000011, 1'b1, c0);
        req(1'b1, 5'd2, 24'h000022, 1'b1, c1);
        req(1'b1, 5'd3, 24'h000033, 1'b1, c2);
        req_valid = 1'b0;
        tick();
        chk("wr_rate_1", c1 - c0, 32'd2);
        chk("wr_rate_2", c2 - c1, 32'd2);
        rd(5'd1); rd(5'd2); rd(5'd3);

        // 4: response back-pressure
        rsp_ready = 1'b0;
        req(1'b0, 5'd0, '0, 1'b1, c0);
        req_valid = 1'b0;
        for (int n = 0; n < 10 && !rsp_valid; n++) tick();
        held = rsp_rdata;
        for (int n = 0; n < 4; n++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_stable", {8'd0, rsp_rdata}, {8'd0, held});
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle", {31'd0, req_ready}, 32'd1);

        // 5a: reset during RD_DATA aborts the read
        rv0 = rv_cnt;
        req(1'b0, 5'd0, '0, 1'b0, c0);
        req_valid = 1'b0;
        tick();
        chk("in_rd_data", {31'd0, ram_oe}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_rd_idle", {31'd0, req_ready}, 32'd1);
        tick(); tick(); tick();
        chk("rst_rd_no_rsp", rv_cnt - rv0, 32'd0);

        // 5b: reset during WRITE suppresses the commit
        ack0 = ack_cnt;
        req(1'b1, 5'd7, 24'hFFFFFF, 1'b0, c0);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_wr_pins", {29'd0, wr_ack, ram_cs, ram_we}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_wr_idle", {31'd0, req_ready}, 32'd1);
        chk("rst_wr_no_ack", ack_cnt - ack0, 32'd0);
        rd(5'd7);
        rd(5'd0);

        tick();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
